dqs_dly_sequencer: RTL and testbench

Sequencer that owns the delay-load ports of the DQS output delay lines: data and tristate `odelay_fine_pipe` instances. It runs in the `clk_div` domain. It accepts single delay-write requests from a host-side requester and drives the shared `delay` bus, per-line `ld` strobes and the common `set` strobe in the required order. It also runs autonomous delay sweeps with a programmable dwell per step, and it holds everything off until the `idelay_ctrl` ready flag is asserted.

---
 rtl/dqs_dly_sequencer_pkg.sv | 24 ++
 rtl/dqs_dly_sequencer_if.sv | 42 ++++
 rtl/dqs_dly_sequencer_sync_2ff.sv | 22 ++
 rtl/dqs_dly_sequencer.sv | 161 ++++++++++++++++
 tb/tb_dqs_dly_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dqs_dly_sequencer_pkg.sv
// Shared types and default parameters for the DQS delay-load sequencer.
package dqs_dly_seq_pkg;

  localparam int NUM_LINES_DEF   = 2;
  localparam int DLY_WIDTH_DEF   = 8;
  localparam int SETTLE_DEF      = 4;
  localparam int DWELL_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    S_WAIT_RDY,
    S_IDLE,
    S_LOAD,
    S_SET,
    S_SETTLE,
    S_SW_LOAD,
    S_SW_SET,
    S_SW_DWELL
  } state_e;

  function automatic int line_w(input int num_lines);
    return (num_lines > 1) ? $clog2(num_lines) : 1;
  endfunction

endpackage

// File: rtl/dqs_dly_sequencer_if.sv
// Host-side request, sweep-control and status bundle of the delay-load sequencer.
interface dqs_dly_seq_if
  import dqs_dly_seq_pkg::*;
#(
  parameter int NUM_LINES   = NUM_LINES_DEF,
  parameter int DLY_WIDTH   = DLY_WIDTH_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) ();

  localparam int LINE_W = line_w(NUM_LINES);

  logic                   req_valid;
  logic                   req_ready;
  logic [LINE_W-1:0]      req_line;
  logic [DLY_WIDTH-1:0]   req_dly;
  logic                   req_commit;

  logic                   sweep_start;
  logic [DLY_WIDTH-1:0]   sweep_first;
  logic [DLY_WIDTH-1:0]   sweep_last;
  logic [NUM_LINES-1:0]   sweep_mask;
  logic [DWELL_WIDTH-1:0] sweep_dwell;
  logic                   sweep_abort;

  logic                   busy;
  logic                   step_strobe;
  logic [DLY_WIDTH-1:0]   step_value;
  logic                   sweep_done;

  modport master (
    output req_valid, req_line, req_dly, req_commit,
    output sweep_start, sweep_first, sweep_last, sweep_mask, sweep_dwell, sweep_abort,
    input  req_ready, busy, step_strobe, step_value, sweep_done
  );

  modport slave (
    input  req_valid, req_line, req_dly, req_commit,
    input  sweep_start, sweep_first, sweep_last, sweep_mask, sweep_dwell, sweep_abort,
    output req_ready, busy, step_strobe, step_value, sweep_done
  );

endinterface

// File: rtl/dqs_dly_sequencer_sync_2ff.sv
// Two-flop synchronizer for a level signal crossing into the clk domain.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state uses non-blocking assignments so both flops sample pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dqs_dly_sequencer.sv
// Drives the shared delay bus, per-line load strobes and the apply strobe for
// single host writes and autonomous delay sweeps, gated by the delay-ctrl ready flag.
module dqs_dly_sequencer
  import dqs_dly_seq_pkg::*;
#(
  parameter int NUM_LINES   = NUM_LINES_DEF,
  parameter int DLY_WIDTH   = DLY_WIDTH_DEF,
  parameter int SETTLE      = SETTLE_DEF,
  parameter int DWELL_WIDTH = DWELL_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dly_ready_in,
  dqs_dly_seq_if.slave         host,
  output logic [DLY_WIDTH-1:0] dly,
  output logic [NUM_LINES-1:0] ld,
  output logic                 set
);

  localparam int LINE_W = line_w(NUM_LINES);

  state_e                 state, state_d;
  logic                   rdy_s;
  logic [DWELL_WIDTH-1:0] cnt;
  logic [DLY_WIDTH-1:0]   cur, last_q, cur_nxt;
  logic                   down_q;
  logic [NUM_LINES-1:0]   mask_q;
  logic [DWELL_WIDTH-1:0] dwell_q;
  logic [LINE_W-1:0]      line_q;
  logic                   commit_q, sweep_mode, abort_pend, busy_q;
  logic                   req_ready_c, step_strobe_c, sweep_done_c;
  logic                   take_req, take_sweep, advance, sweep_active;

  sync_2ff u_rdy_sync (.clk(clk), .rst(rst), .d(dly_ready_in), .q(rdy_s));

  assign cur_nxt = down_q ? cur - DLY_WIDTH'(1) : cur + DLY_WIDTH'(1);
  assign sweep_active = sweep_mode &&
                        (state inside {S_SW_LOAD, S_SW_SET, S_SETTLE, S_SW_DWELL});

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d       = state;
    req_ready_c   = 1'b0;
    ld            = '0;
    set           = 1'b0;
    step_strobe_c = 1'b0;
    sweep_done_c  = 1'b0;
    take_req      = 1'b0;
    take_sweep    = 1'b0;
    advance       = 1'b0;
    if (state != S_WAIT_RDY && !rdy_s) begin
      // Ready loss silences all strobes and drops any accepted-but-unfinished work.
      state_d      = S_WAIT_RDY;
      sweep_done_c = sweep_active;
    end else begin
      unique case (state)
        S_WAIT_RDY: if (rdy_s) state_d = S_IDLE;
        S_IDLE: begin
          if (host.sweep_start) begin
            take_sweep = 1'b1;
            state_d    = S_SW_LOAD;
          end else begin
            req_ready_c = 1'b1;
            if (host.req_valid) begin
              take_req = 1'b1;
              state_d  = S_LOAD;
            end
          end
        end
        S_LOAD: begin
          ld      = NUM_LINES'(1) << line_q;
          state_d = commit_q ? S_SET : S_IDLE;
        end
        S_SET: begin
          set     = 1'b1;
          state_d = S_SETTLE;
        end
        S_SETTLE: begin
          if (cnt == DWELL_WIDTH'(SETTLE - 1)) state_d = sweep_mode ? S_SW_DWELL : S_IDLE;
        end
        S_SW_LOAD: begin
          ld      = mask_q;
          state_d = S_SW_SET;
        end
        S_SW_SET: begin
          set     = 1'b1;
          state_d = S_SETTLE;
        end
        S_SW_DWELL: begin
          if (host.sweep_abort || abort_pend) begin
            sweep_done_c = 1'b1;
            state_d      = S_IDLE;
          end else if (cnt == dwell_q) begin
            step_strobe_c = 1'b1;
            if (cur == last_q) begin
              sweep_done_c = 1'b1;
              state_d      = S_IDLE;
            end else begin
              advance = 1'b1;
              state_d = S_SW_LOAD;
            end
          end
        end
        default: state_d = S_WAIT_RDY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_WAIT_RDY;
      busy_q     <= 1'b0;
      cnt        <= '0;
      cur        <= '0;
      last_q     <= '0;
      down_q     <= 1'b0;
      mask_q     <= '0;
      dwell_q    <= '0;
      line_q     <= '0;
      commit_q   <= 1'b0;
      sweep_mode <= 1'b0;
      abort_pend <= 1'b0;
      dly        <= '0;
    end else begin
      state  <= state_d;
      busy_q <= (state_d != S_IDLE);
      // One counter serves both SETTLE and dwell; it restarts on every state change.
      cnt    <= (state_d != state) ? '0 : cnt + DWELL_WIDTH'(1);
      if (take_req) begin
        line_q     <= host.req_line;
        dly        <= host.req_dly;
        commit_q   <= host.req_commit;
        sweep_mode <= 1'b0;
      end
      if (take_sweep) begin
        cur        <= host.sweep_first;
        dly        <= host.sweep_first;
        last_q     <= host.sweep_last;
        down_q     <= (host.sweep_last < host.sweep_first);
        mask_q     <= host.sweep_mask;
        dwell_q    <= (host.sweep_dwell == '0) ? DWELL_WIDTH'(1) : host.sweep_dwell;
        sweep_mode <= 1'b1;
        abort_pend <= 1'b0;
      end else if (host.sweep_abort && sweep_mode &&
                   (state inside {S_SW_LOAD, S_SW_SET, S_SETTLE})) begin
        abort_pend <= 1'b1;
      end
      if (advance) begin
        cur <= cur_nxt;
        dly <= cur_nxt;
      end
    end
  end

  assign host.req_ready   = req_ready_c;
  assign host.busy        = busy_q;
  assign host.step_strobe = step_strobe_c;
  assign host.step_value  = cur;
  assign host.sweep_done  = sweep_done_c;

endmodule

// File: tb/tb_dqs_dly_sequencer.sv
// Self-checking bench: observed strobe events are compared against timelines
// derived arithmetically from the request and sweep timing rules.
module tb_dqs_dly_sequencer;
  import dqs_dly_seq_pkg::*;

  localparam int NL = 2;
  localparam int DW = 8;
  localparam int S  = 4;
  localparam int WW = 16;
  localparam int K_LD = 0, K_SET = 1, K_STEP = 2, K_DONE = 3;

  typedef struct {
    int cyc;
    int kind;
    int val;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          dly_ready_in;
  logic [DW-1:0] dly;
  logic [NL-1:0] ld;
  logic          set;

  int  cyc   = 0;
  int  tests = 0;
  int  fails = 0;
  ev_t obs_q[$];
  ev_t exp_q[$];

  dqs_dly_seq_if #(.NUM_LINES(NL), .DLY_WIDTH(DW), .DWELL_WIDTH(WW)) bus ();

  dqs_dly_sequencer #(
    .NUM_LINES(NL), .DLY_WIDTH(DW), .SETTLE(S), .DWELL_WIDTH(WW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .dly_ready_in (dly_ready_in),
    .host         (bus.slave),
    .dly          (dly),
    .ld           (ld),
    .set          (set)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ld != '0)         obs_q.push_back('{cyc, K_LD, int'({ld, dly})});
    if (set)              obs_q.push_back('{cyc, K_SET, 0});
    if (bus.step_strobe)  obs_q.push_back('{cyc, K_STEP, int'(bus.step_value)});
    if (bus.sweep_done)   obs_q.push_back('{cyc, K_DONE, 0});
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick();
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (bus.busy === 1'b0) break;
    end
    check(tag, bus.busy, 1'b0);
    tick();
  endtask

  task automatic exp_push(input int c, input int k, input int v, input int cut);
    if (cut < 0 || c < cut) exp_q.push_back('{c, k, v});
  endtask

  // Full sweep timeline; with cut >= 0 everything from cut onward is replaced by a single done.
  task automatic model_sweep(input int first, input int last, input int mask,
                             input int dwell, input int t0, input int cut);
    int n, dir, dw, p, v, base;
    dir  = (last >= first) ? 1 : -1;
    n    = ((last >= first) ? last - first : first - last) + 1;
    dw   = (dwell == 0) ? 1 : dwell;
    p    = 3 + S + dw;
    for (int k = 0; k < n; k++) begin
      v    = first + dir * k;
      base = t0 + k * p;
      if (mask != 0) exp_push(base + 1, K_LD, (mask << DW) | v, cut);
      exp_push(base + 2, K_SET, 0, cut);
      exp_push(base + p, K_STEP, v, cut);
      if (k == n - 1) exp_push(base + p, K_DONE, 0, cut);
    end
    if (cut >= 0) exp_q.push_back('{cut, K_DONE, 0});
  endtask

  task automatic cmp_events(input string tag);
    check({tag, "_count"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      check($sformatf("%s_ev%0d_cyc", tag, i), obs_q[i].cyc, exp_q[i].cyc);
      check($sformatf("%s_ev%0d_kind", tag, i), obs_q[i].kind, exp_q[i].kind);
      check($sformatf("%s_ev%0d_val", tag, i), obs_q[i].val, exp_q[i].val);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_req(input int line, input int code, input bit commit, output int t);
    bus.req_valid  = 1'b1;
    bus.req_line   = line[0];
    bus.req_dly    = code[DW-1:0];
    bus.req_commit = commit;
    @(negedge clk);
    check("req_ready_at_accept", bus.req_ready, 1'b1);
    t = cyc;
    tick();
    bus.req_valid = 1'b0;
  endtask

  task automatic run_req(input string tag, input int line, input int code, input bit commit);
    int t, rc;
    obs_q.delete();
    exp_q.delete();
    do_req(line, code, commit, t);
    exp_push(t + 1, K_LD, ((1 << line) << DW) | code, -1);
    if (commit) exp_push(t + 2, K_SET, 0, -1);
    rc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        rc = cyc;
        break;
      end
    end
    check({tag, "_ready_return"}, rc - t, commit ? 3 + S : 2);
    wait_idle({tag, "_idle"});
    cmp_events(tag);
  endtask

  task automatic start_sweep(input int first, input int last, input int mask,
                             input int dwell, output int t0);
    bus.sweep_start = 1'b1;
    bus.sweep_first = first[DW-1:0];
    bus.sweep_last  = last[DW-1:0];
    bus.sweep_mask  = mask[NL-1:0];
    bus.sweep_dwell = dwell[WW-1:0];
    @(negedge clk);
    t0 = cyc;
    tick();
    bus.sweep_start = 1'b0;
    // Scramble the inputs so only latched values can produce the right steps.
    bus.sweep_first = DW'($urandom);
    bus.sweep_last  = DW'($urandom);
    bus.sweep_mask  = NL'($urandom);
    bus.sweep_dwell = WW'($urandom);
  endtask

  initial begin
    int t0, t1, t2, c, rise, p, dw, first, last, len, mask, dwell, ca;

    rst              = 1'b0;
    dly_ready_in     = 1'b0;
    bus.req_valid    = 1'b0;
    bus.req_line     = '0;
    bus.req_dly      = '0;
    bus.req_commit   = 1'b0;
    bus.sweep_start  = 1'b0;
    bus.sweep_first  = '0;
    bus.sweep_last   = '0;
    bus.sweep_mask   = '0;
    bus.sweep_dwell  = '0;
    bus.sweep_abort  = 1'b0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_dly", dly, '0);
    check("rst_ld", ld, '0);
    check("rst_set", set, 1'b0);
    check("rst_busy", bus.busy, 1'b0);
    check("rst_step", {bus.step_strobe, bus.step_value, bus.sweep_done}, '0);
    tick();
    rst = 1'b1;

    // Ready held low: nothing moves
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("wait_quiet_%0d", i),
            {bus.req_ready, ld, set, bus.step_strobe, bus.sweep_done, dly}, '0);
    end
    tick();
    dly_ready_in = 1'b1;
    c    = cyc;
    rise = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        rise = cyc;
        break;
      end
    end
    check("ready_rise_latency", rise - c, 3);
    tick();
    obs_q.delete();

    // Directed commit write, then random writes
    run_req("req_5a", 1, 8'h5A, 1'b1);
    for (int r = 0; r < 6; r++)
      run_req($sformatf("req_rnd%0d", r), $urandom_range(0, 1), $urandom_range(0, 255),
              1'($urandom_range(0, 1)));

    // Back-to-back writes without commit
    obs_q.delete();
    exp_q.delete();
    c = $urandom_range(0, 255);
    bus.req_valid  = 1'b1;
    bus.req_line   = 1'b0;
    bus.req_dly    = c[DW-1:0];
    bus.req_commit = 1'b0;
    @(negedge clk);
    check("b2b_first_ready", bus.req_ready, 1'b1);
    t1 = cyc;
    tick();
    len = $urandom_range(0, 255);
    bus.req_line = 1'b1;
    bus.req_dly  = len[DW-1:0];
    t2 = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        t2 = cyc;
        break;
      end
    end
    check("b2b_gap", t2 - t1, 2);
    tick();
    bus.req_valid = 1'b0;
    exp_push(t1 + 1, K_LD, (1 << DW) | c, -1);
    exp_push(t1 + 3, K_LD, (2 << DW) | len, -1);
    wait_idle("b2b_idle");
    cmp_events("b2b");

    // Directed descending sweep 3 -> 1
    start_sweep(3, 1, 3, 2, t0);
    model_sweep(3, 1, 3, 2, t0, -1);
    wait_idle("sw_down_idle");
    cmp_events("sw_down");

    // Random short sweeps, including zero mask, zero dwell and a single step at the top code
    for (int r = 0; r < 4; r++) begin
      first = $urandom_range(0, 255);
      len   = $urandom_range(0, 4);
      if ($urandom_range(0, 1) == 1) last = (first + len > 255) ? 255 : first + len;
      else                          last = (first - len < 0) ? 0 : first - len;
      mask  = (r == 0) ? 0 : $urandom_range(1, 3);
      dwell = (r == 0) ? 0 : $urandom_range(0, 3);
      if (r == 1) begin
        first = 255;
        last  = 255;
      end
      start_sweep(first, last, mask, dwell, t0);
      model_sweep(first, last, mask, dwell, t0, -1);
      wait_idle($sformatf("sw_rnd%0d_idle", r));
      cmp_events($sformatf("sw_rnd%0d", r));
    end

    // Sweep start wins over a simultaneous request; abort inside the 5th dwell
    dwell = $urandom_range(1, 4);
    dw    = dwell;
    p     = 3 + S + dw;
    bus.req_valid  = 1'b1;
    bus.req_line   = 1'b0;
    bus.req_dly    = 8'hC3;
    bus.req_commit = 1'b1;
    bus.sweep_start = 1'b1;
    bus.sweep_first = 8'd0;
    bus.sweep_last  = 8'd255;
    bus.sweep_mask  = 2'b01;
    bus.sweep_dwell = dwell[WW-1:0];
    @(negedge clk);
    check("collide_req_ready", bus.req_ready, 1'b0);
    t0 = cyc;
    tick();
    bus.sweep_start = 1'b0;
    bus.req_valid   = 1'b0;
    ca = t0 + 4 * p + 3 + S + $urandom_range(0, dw);
    wait_until(ca);
    bus.sweep_abort = 1'b1;
    tick();
    bus.sweep_abort = 1'b0;
    @(negedge clk);
    check("abort_idle_next", bus.busy, 1'b0);
    model_sweep(0, 255, 1, dwell, t0, ca);
    wait_idle("abort_idle");
    cmp_events("sw_abort");

    // Abort raised before the dwell is held until the dwell starts
    dwell = $urandom_range(1, 3);
    p     = 3 + S + dwell;
    start_sweep(10, 20, 2, dwell, t0);
    ca = t0 + 1 + 2 * p + $urandom_range(0, 1 + S);
    wait_until(ca);
    bus.sweep_abort = 1'b1;
    tick();
    bus.sweep_abort = 1'b0;
    model_sweep(10, 20, 2, dwell, t0, t0 + 3 + S + 2 * p);
    wait_idle("lat_abort_idle");
    cmp_events("sw_lat_abort");

    // Ready loss mid-sweep
    dwell = $urandom_range(0, 3);
    dw    = (dwell == 0) ? 1 : dwell;
    p     = 3 + S + dw;
    start_sweep(0, 200, 3, dwell, t0);
    c = t0 + $urandom_range(5, 3 * p);
    wait_until(c);
    dly_ready_in = 1'b0;
    wait_until(c + 3);
    @(negedge clk);
    check("drop_wait_busy", bus.busy, 1'b1);
    check("drop_wait_ready", bus.req_ready, 1'b0);
    repeat (4) tick();
    model_sweep(0, 200, 3, dwell, t0, c + 2);
    cmp_events("sw_drop");
    dly_ready_in = 1'b1;
    c    = cyc;
    rise = -1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.req_ready) begin
        rise = cyc;
        break;
      end
    end
    check("reassert_rise_latency", rise - c, 3);
    tick();
    run_req("req_after_drop", 0, $urandom_range(0, 255), 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
